// File: rtl/param_sync_fifo_if.sv
// Handshake and status bundle for param_sync_fifo.
// The master drives writes/reads; the slave (the FIFO) returns data and level/status flags.
interface param_sync_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic [CNT_W-1:0]      count;

  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, full, empty, almostfull, almostempty,
    input  wr_ack, overflow, underflow, count
  );

  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, full, empty, almostfull, almostempty,
    output wr_ack, overflow, underflow, count
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO of arbitrary depth with level flags, per-request status and
// selectable registered-read or first-word-fall-through output.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0
) (
  input logic              clk,
  input logic              rst,
  param_sync_fifo_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ack_q, wr_ack_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_accept;
  logic             rd_accept;

  // A write into a full FIFO is still legal when a read frees the slot in the same cycle.
  always_comb begin
    rd_accept   = bus.rd_en && (count_q != '0);
    wr_accept   = bus.wr_en && ((count_q != CNT_MAX) || bus.rd_en);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ack_d    = wr_accept;
    overflow_d  = bus.wr_en && !wr_accept;
    underflow_d = bus.rd_en && (count_q == '0);

    if (wr_accept) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_accept) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_accept && !rst) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] data_out_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_out_q <= '0;
        end else if (rd_accept) begin
          data_out_q <= mem_q[rd_ptr_q];
        end
      end

      assign bus.data_out = data_out_q;
    end
  endgenerate

  assign bus.count       = count_q;
  assign bus.full        = (count_q == CNT_MAX);
  assign bus.empty       = (count_q == '0);
  assign bus.almostfull  = (count_q >= AF_LVL);
  assign bus.almostempty = (count_q <= AE_LVL);
  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule
